// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART slot scheduler:
// FSM states, command kinds, slot register map and status word layout.
package uart_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_CMD  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Kind of slot write held in the command registers
  typedef enum logic [1:0] {
    CMD_INIT = 2'd0,
    CMD_CFG  = 2'd1,
    CMD_RX   = 2'd2,
    CMD_TX   = 2'd3
  } cmd_e;

  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_DVSR   = 5'd1;
  localparam logic [4:0] ADDR_TX     = 5'd2;
  localparam logic [4:0] ADDR_RX_POP = 5'd3;

  localparam int TX_FULL_BIT  = 9;
  localparam int RX_EMPTY_BIT = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way TX arbiter: round-robin on a tie (or fixed priority to requester 0),
// with the fairness pointer moving only when a grant is actually issued.
module rr_arb2 #(
  parameter bit RR = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       issue,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  // last_q=1 means requester 1 won last, so requester 0 wins the first tie after reset
  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = (RR && !last_q) ? 2'b10 : 2'b01;
    end
    if (issue && (gnt != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/uart_slot_sched.sv
// Time-slot scheduler driving a UART register slot: polls status in IDLE,
// issues one divisor, RX-pop or TX write per three cycles.
module uart_slot_sched
  import uart_sched_pkg::*;
#(
  parameter logic [10:0] DVSR_INIT  = 11'd650,
  parameter int          TX_PRIO_RR = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_wr,
  input  logic [10:0] cfg_dvsr,
  output logic        cfg_busy,
  input  logic [1:0]  tx_req,
  input  logic [7:0]  tx_data0,
  input  logic [7:0]  tx_data1,
  output logic [1:0]  tx_ack,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        slot_cs,
  output logic        slot_read,
  output logic        slot_write,
  output logic [4:0]  slot_addr,
  output logic [31:0] slot_wr_data,
  input  logic [31:0] slot_rd_data
);

  state_e      state_q, state_d;
  cmd_e        cmd_kind_q, cmd_kind_d;
  logic [4:0]  cmd_addr_q, cmd_addr_d;
  logic [31:0] cmd_data_q, cmd_data_d;
  logic [1:0]  tx_gnt_q, tx_gnt_d;
  logic        cfg_pend_q, cfg_pend_d;
  logic [10:0] cfg_dvsr_q, cfg_dvsr_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        cfg_busy_q, cfg_busy_d;

  logic        tx_full, rx_empty, sel_rx, sel_tx, tx_issue, in_cmd;
  logic [1:0]  gnt;
  logic        rd_unused;

  assign tx_full   = slot_rd_data[TX_FULL_BIT];
  assign rx_empty  = slot_rd_data[RX_EMPTY_BIT];
  assign rd_unused = ^slot_rd_data[31:10];
  assign sel_rx    = !rx_empty && !rx_valid_q;
  assign sel_tx    = !tx_full && (tx_req != 2'b00);

  rr_arb2 #(.RR(TX_PRIO_RR != 0)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (tx_req),
    .issue   (tx_issue),
    .gnt     (gnt)
  );

  always_comb begin
    state_d    = state_q;
    cmd_kind_d = cmd_kind_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    tx_gnt_d   = tx_gnt_q;
    cfg_pend_d = cfg_pend_q;
    cfg_dvsr_d = cfg_dvsr_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    tx_issue   = 1'b0;
    if (cfg_wr) begin
      cfg_pend_d = 1'b1;
      cfg_dvsr_d = cfg_dvsr;
    end
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    case (state_q)
      ST_INIT: begin
        cmd_kind_d = CMD_INIT;
        cmd_addr_d = ADDR_DVSR;
        cmd_data_d = {21'b0, DVSR_INIT};
        state_d    = ST_CMD;
      end
      ST_IDLE: begin
        if (cfg_pend_q) begin
          cmd_kind_d = CMD_CFG;
          cmd_addr_d = ADDR_DVSR;
          cmd_data_d = 32'd0;
          state_d    = ST_CMD;
        end else if (sel_rx) begin
          cmd_kind_d = CMD_RX;
          cmd_addr_d = ADDR_RX_POP;
          cmd_data_d = 32'd0;
          rx_data_d  = slot_rd_data[7:0];
          state_d    = ST_CMD;
        end else if (sel_tx) begin
          cmd_kind_d = CMD_TX;
          cmd_addr_d = ADDR_TX;
          cmd_data_d = {24'b0, (gnt[1] ? tx_data1 : tx_data0)};
          tx_gnt_d   = gnt;
          tx_issue   = 1'b1;
          state_d    = ST_CMD;
        end
      end
      ST_CMD: begin
        // A cfg_wr landing on this very cycle keeps the newer value pending
        if ((cmd_kind_q == CMD_CFG) && !cfg_wr) begin
          cfg_pend_d = 1'b0;
        end
        if (cmd_kind_q == CMD_RX) begin
          rx_valid_d = 1'b1;
        end
        state_d = ST_GAP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cfg_busy_d = (state_q == ST_INIT) || cfg_pend_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      cmd_kind_q <= CMD_INIT;
      cmd_addr_q <= 5'd0;
      cmd_data_q <= 32'd0;
      tx_gnt_q   <= 2'b00;
      cfg_pend_q <= 1'b0;
      cfg_dvsr_q <= 11'd0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
      cfg_busy_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cmd_kind_q <= cmd_kind_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      tx_gnt_q   <= tx_gnt_d;
      cfg_pend_q <= cfg_pend_d;
      cfg_dvsr_q <= cfg_dvsr_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      cfg_busy_q <= cfg_busy_d;
    end
  end

  // Divisor writes read cfg_dvsr_q directly so a late overwrite still lands
  assign in_cmd       = (state_q == ST_CMD);
  assign slot_cs      = in_cmd || (state_q == ST_IDLE);
  assign slot_read    = (state_q == ST_IDLE);
  assign slot_write   = in_cmd;
  assign slot_addr    = in_cmd ? cmd_addr_q : ADDR_STATUS;
  assign slot_wr_data = !in_cmd ? 32'd0 :
                        (cmd_kind_q == CMD_CFG) ? {21'b0, cfg_dvsr_q} : cmd_data_q;
  assign tx_ack       = (in_cmd && (cmd_kind_q == CMD_TX)) ? tx_gnt_q : 2'b00;
  assign rx_valid     = rx_valid_q;
  assign rx_data      = rx_data_q;
  assign cfg_busy     = cfg_busy_q;

endmodule
